conv_window_mac: RTL and testbench



---
 rtl/conv_window_mac.sv | 148 ++++++++++++++
 tb/tb_conv_window_mac.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_mac.sv
// Streaming KxK multi-channel convolution MAC: kernel load, per-window accumulate, saturated result.
// Define CONV_WINDOW_MAC_RELU_EN to clamp negative results to zero (fused ReLU).
module conv_window_mac #(
    parameter int KERNEL_SIZE = 3,
    parameter int CHANNELS    = 1,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_SHIFT   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_keep_kernel,
    input  logic                  i_kernel_valid,
    input  logic [DATA_WIDTH-1:0] i_kernel_data,
    output logic                  o_kernel_ready,
    input  logic                  i_pix_valid,
    input  logic [DATA_WIDTH-1:0] i_pix_data,
    input  logic                  i_pix_last,
    output logic                  o_pix_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int N  = KERNEL_SIZE * KERNEL_SIZE * CHANNELS;
    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KERNEL,
        S_ACCUM,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [TW-1:0]                tap_q, tap_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         last_q, last_d;
    logic signed [DATA_WIDTH-1:0] kernel_q [N];

    logic                         kern_fire, pix_fire, tap_end;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext, shifted;
    logic [DATA_WIDTH-1:0]        sat;

    assign o_kernel_ready = (state_q == S_LOAD_KERNEL);
    assign o_pix_ready    = (state_q == S_ACCUM);
    assign o_result_valid = (state_q == S_OUTPUT);
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = (state_q == S_DONE);

    assign kern_fire = i_kernel_valid && o_kernel_ready;
    assign pix_fire  = i_pix_valid && o_pix_ready;
    assign tap_end   = (tap_q == TW'(N - 1));

    assign prod     = $signed(i_pix_data) * kernel_q[tap_q];
    assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

    // Kernel is retained across jobs and resets so i_keep_kernel can reuse it.
    always_ff @(posedge i_clk) begin
        if (kern_fire) kernel_q[tap_q] <= $signed(i_kernel_data);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            acc_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        acc_d   = acc_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    tap_d   = '0;
                    acc_d   = '0;
                    state_d = i_keep_kernel ? S_ACCUM : S_LOAD_KERNEL;
                end
            end
            S_LOAD_KERNEL: begin
                if (kern_fire) begin
                    if (tap_end) begin
                        tap_d   = '0;
                        state_d = S_ACCUM;
                    end else begin
                        tap_d = tap_q + TW'(1);
                    end
                end
            end
            S_ACCUM: begin
                if (pix_fire) begin
                    acc_d = acc_q + prod_ext;
                    if (tap_end) begin
                        tap_d   = '0;
                        last_d  = i_pix_last;
                        state_d = S_OUTPUT;
                    end else begin
                        tap_d = tap_q + TW'(1);
                    end
                end
            end
            S_OUTPUT: begin
                if (i_result_ready) begin
                    acc_d   = '0;
                    state_d = last_q ? S_DONE : S_ACCUM;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign shifted = acc_q >>> OUT_SHIFT;

    always_comb begin
        if (shifted > SAT_MAX)      sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
        else                        sat = shifted[DATA_WIDTH-1:0];
`ifdef CONV_WINDOW_MAC_RELU_EN
        if (sat[DATA_WIDTH-1]) sat = '0;
`endif
    end

    // acc is frozen in OUTPUT, so the result stays stable under backpressure.
    assign o_result = (state_q == S_OUTPUT) ? sat : '0;

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac: directed corner jobs plus randomized jobs vs. a sum-of-products model.
module tb_conv_window_mac;

    localparam int K  = 3;
    localparam int C  = 1;
    localparam int DW = 8;
    localparam int AW = 24;
    localparam int SH = 0;
    localparam int N  = K * K * C;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start, i_keep_kernel;
    logic          i_kernel_valid;
    logic [DW-1:0] i_kernel_data;
    logic          o_kernel_ready;
    logic          i_pix_valid;
    logic [DW-1:0] i_pix_data;
    logic          i_pix_last;
    logic          o_pix_ready;
    logic [DW-1:0] o_result;
    logic          o_result_valid;
    logic          i_result_ready;
    logic          o_busy, o_done;

    conv_window_mac #(
        .KERNEL_SIZE(K), .CHANNELS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_SHIFT(SH)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_keep_kernel(i_keep_kernel),
        .i_kernel_valid(i_kernel_valid), .i_kernel_data(i_kernel_data), .o_kernel_ready(o_kernel_ready),
        .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .i_pix_last(i_pix_last),
        .o_pix_ready(o_pix_ready), .o_result(o_result), .o_result_valid(o_result_valid),
        .i_result_ready(i_result_ready), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int done_cnt = 0;
    int exp_done = 0;
    int kready_cycles = 0;
    bit rand_rdy = 1'b0;
    bit rdy_force = 1'b1;
    int kern[N];
    int pix[N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain dot product, arithmetic shift, clamp to the signed output range.
    function automatic int ref_win(input int kk[N], input int pp[N]);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(kk[i]) * longint'(pp[i]);
        s = s >>> SH;
        if (s > (2**(DW-1)) - 1) s = (2**(DW-1)) - 1;
        if (s < -(2**(DW-1)))    s = -(2**(DW-1));
`ifdef CONV_WINDOW_MAC_RELU_EN
        if (s < 0) s = 0;
`endif
        return int'(s);
    endfunction

    always @(posedge i_clk) begin
        #1;
        i_result_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Monitor: the handshake completes at the next posedge, so pop on the negedge before it.
    always @(negedge i_clk) begin
        if (o_kernel_ready) kready_cycles++;
        if (o_done) done_cnt++;
        if (!i_rst && o_result_valid && i_result_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", int'($signed(o_result)), -999);
            else chk("result", int'($signed(o_result)), exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_job(input bit keep);
        i_start = 1'b1;
        i_keep_kernel = keep;
        tick();
        i_start = 1'b0;
        i_keep_kernel = 1'b0;
    endtask

    task automatic send_kernel(input bit gaps);
        bit a;
        int t;
        for (int i = 0; i < N; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            i_kernel_valid = 1'b1;
            i_kernel_data  = DW'(kern[i]);
            t = 0;
            do begin
                @(negedge i_clk);
                a = o_kernel_ready;
                @(posedge i_clk);
                #1;
                t++;
            end while (!a && t < 200);
            if (!a) chk("kernel_handshake_timeout", 0, 1);
            i_kernel_valid = 1'b0;
        end
    endtask

    task automatic send_pixels(input int nb, input bit last, input bit gaps);
        bit a;
        int t;
        if (nb == N) exp_q.push_back(ref_win(kern, pix));
        for (int i = 0; i < nb; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            i_pix_valid = 1'b1;
            i_pix_data  = DW'(pix[i]);
            i_pix_last  = (i == N - 1) ? last : 1'($urandom_range(0, 1));
            t = 0;
            do begin
                @(negedge i_clk);
                a = o_pix_ready;
                @(posedge i_clk);
                #1;
                t++;
            end while (!a && t < 200);
            if (!a) chk("pix_handshake_timeout", 0, 1);
            i_pix_valid = 1'b0;
            i_pix_last  = 1'b0;
        end
        if (nb == N) begin
            @(negedge i_clk);
            chk("result_valid_latency", int'(o_result_valid), 1);
            chk("pix_ready_in_output", int'(o_pix_ready), 0);
        end
    endtask

    task automatic wait_done(input string name);
        bit a = 1'b0;
        int t = 0;
        int d0 = done_cnt;
        exp_done++;
        while (!a && t < 1000) begin
            @(negedge i_clk);
            a = o_done;
            t++;
        end
        chk(name, int'(a), 1);
        @(negedge i_clk);
        chk("done_one_cycle", int'(o_done), 0);
        chk("idle_after_done", int'(o_busy), 0);
        chk("done_count", done_cnt - d0, 1);
        tick();
    endtask

    initial begin
        int e1, kr0, d0, nw;
        bit keep;
        i_rst = 1'b1;
        i_start = 0; i_keep_kernel = 0; i_kernel_valid = 0; i_kernel_data = 0;
        i_pix_valid = 0; i_pix_data = 0; i_pix_last = 0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_kernel_ready", int'(o_kernel_ready), 0);
        chk("rst_pix_ready", int'(o_pix_ready), 0);
        chk("rst_result_valid", int'(o_result_valid), 0);
        chk("rst_result", int'(o_result), 0);
        chk("rst_done", int'(o_done), 0);
        i_rst = 1'b0;
        tick();

        // All-ones kernel, pixels 1..9 -> 45
        for (int i = 0; i < N; i++) begin kern[i] = 1; pix[i] = i + 1; end
        start_job(1'b0);
        send_kernel(1'b0);
        send_pixels(N, 1'b1, 1'b0);
        wait_done("t1_done");

        // Kernel reuse: no kernel beats requested
        kr0 = kready_cycles;
        for (int i = 0; i < N; i++) pix[i] = 2;
        start_job(1'b1);
        send_pixels(N, 1'b1, 1'b0);
        wait_done("t5_done");
        chk("t5_no_kernel_request", kready_cycles - kr0, 0);

        // Reset mid-window discards partial sum and produces no o_done
        for (int i = 0; i < N; i++) pix[i] = i + 1;
        start_job(1'b1);
        send_pixels(4, 1'b0, 1'b0);
        d0 = done_cnt;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("t6_rst_busy", int'(o_busy), 0);
        chk("t6_rst_pix_ready", int'(o_pix_ready), 0);
        tick();
        i_rst = 1'b0;
        tick();
        chk("t6_no_done_on_reset", done_cnt - d0, 0);
        start_job(1'b1);
        send_pixels(N, 1'b1, 1'b0);
        wait_done("t6_done");

        // Saturation both directions, negative result (ReLU-aware via model)
        for (int i = 0; i < N; i++) begin kern[i] = 127; pix[i] = 127; end
        start_job(1'b0); send_kernel(1'b0); send_pixels(N, 1'b1, 1'b0); wait_done("t2_pos_done");
        for (int i = 0; i < N; i++) kern[i] = -128;
        start_job(1'b0); send_kernel(1'b1); send_pixels(N, 1'b1, 1'b1); wait_done("t2_neg_done");
        for (int i = 0; i < N; i++) begin kern[i] = -1; pix[i] = 10; end
        start_job(1'b0); send_kernel(1'b0); send_pixels(N, 1'b1, 1'b0); wait_done("t3_done");

        // Backpressure: hold first result 5 cycles with a pixel pending
        rdy_force = 1'b0;
        tick(); tick();
        for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 20) - 10;
        e1 = ref_win(kern, pix);
        start_job(1'b1);
        send_pixels(N, 1'b0, 1'b0);
        i_pix_valid = 1'b1;
        i_pix_data  = 8'd55;
        repeat (5) begin
            @(negedge i_clk);
            chk("t4_hold_valid", int'(o_result_valid), 1);
            chk("t4_hold_result", int'($signed(o_result)), e1);
            chk("t4_hold_pix_ready", int'(o_pix_ready), 0);
        end
        i_pix_valid = 1'b0;
        tick();
        rdy_force = 1'b1;
        for (int i = 0; i < N; i++) pix[i] = i * 3 - 7;
        send_pixels(N, 1'b1, 1'b0);
        wait_done("t4_done");

        // Randomized jobs with gaps and random result backpressure
        rand_rdy = 1'b1;
        for (int j = 0; j < 6; j++) begin
            keep = (j > 0) && ($urandom_range(0, 1) == 1);
            if (!keep) for (int i = 0; i < N; i++) kern[i] = $urandom_range(0, 255) - 128;
            start_job(keep);
            if (!keep) send_kernel(1'b1);
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 255) - 128;
                send_pixels(N, w == nw - 1, 1'b1);
            end
            wait_done("rand_done");
        end
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        repeat (3) tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("total_done_pulses", done_cnt, exp_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
